// File: rtl/dct_seq.sv
// dct_seq
// Block buffer and beat sequencer that sits in front of the DCT coefficient
// ROM. Raster pixels of 8x8 blocks are written into a two-bank ping-pong
// buffer. A finished bank is then replayed as 512 beats, one for each
// (u, v, i) triple. Each beat carries:
//   - the ROM row/column selects (u, v),
//   - the accumulation index i,
//   - the eight level-shifted pixels of row i.
//
// Ports
//   i_clk, i_rst_n         clock; asynchronous active-low reset
//   i_pix_valid/o_pix_ready/i_pix_data   pixel input handshake, 8-bit pixel
//   o_row_sel, o_col_sel   ROM selects (u, v)
//   o_x_sel                row index i of the current beat
//   o_x_row                X[i][j] = pix(i,j) - 128, signed, j = 0..7
//   o_beat_valid/i_beat_ready            beat handshake
//   o_beat_first           i == 0
//   o_beat_last            i == 7
//   o_blk_last             u == v == i == 7
module dct_seq (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pix_valid,
  output logic            o_pix_ready,
  input  logic [7:0]      i_pix_data,
  output logic [2:0]      o_row_sel,
  output logic [2:0]      o_col_sel,
  output logic [2:0]      o_x_sel,
  output logic [7:0][7:0] o_x_row,
  output logic            o_beat_valid,
  input  logic            i_beat_ready,
  output logic            o_beat_first,
  output logic            o_beat_last,
  output logic            o_blk_last
);

  typedef enum logic {RD_IDLE = 1'b0, RD_RUN = 1'b1} rd_state_t;

  rd_state_t  r_state;
  rd_state_t  w_state_nxt;

  logic [7:0] r_mem [2][64];
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [5:0] r_wr_cnt;
  logic [1:0] r_full;
  logic [2:0] r_u;
  logic [2:0] r_v;
  logic [2:0] r_i;

  logic       w_wr_fire;
  logic       w_wr_done;
  logic       w_beat_fire;
  logic       w_blk_done;
  logic [1:0] w_full_set;
  logic [1:0] w_full_clr;
  logic [8:0] w_diff [8];

  // Ready looks only at the registered full flag. A bank freed this cycle
  // therefore starts accepting pixels on the next cycle.
  assign o_pix_ready = !r_full[r_wr_bank];
  assign w_wr_fire   = i_pix_valid && o_pix_ready;
  assign w_wr_done   = w_wr_fire && (r_wr_cnt == 6'd63);
  assign w_beat_fire = o_beat_valid && i_beat_ready;
  assign w_blk_done  = w_beat_fire && o_blk_last;

  // The set and clear always target different banks, so both can apply
  // in the same cycle.
  assign w_full_set = w_wr_done  ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_full_clr = w_blk_done ? (2'b01 << r_rd_bank) : 2'b00;

  // Pixel storage. It has no reset: nothing is read from a bank until that
  // bank has been completely written.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_bank][r_wr_cnt] <= i_pix_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= 6'd0;
      r_full    <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
        if (w_wr_done) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (r_full[r_rd_bank]) w_state_nxt = RD_RUN;
      RD_RUN:  if (w_blk_done)        w_state_nxt = RD_IDLE;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // The counters advance as one 9-bit counter {u,v,i}, with i the fastest
  // digit. It wraps to zero on the last beat of the block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_bank <= 1'b0;
      r_u       <= 3'd0;
      r_v       <= 3'd0;
      r_i       <= 3'd0;
    end else if (w_blk_done) begin
      r_rd_bank <= ~r_rd_bank;
      r_u       <= 3'd0;
      r_v       <= 3'd0;
      r_i       <= 3'd0;
    end else if (w_beat_fire) begin
      {r_u, r_v, r_i} <= {r_u, r_v, r_i} + 9'd1;
    end
  end

  assign o_beat_valid = (r_state == RD_RUN);
  assign o_row_sel    = r_u;
  assign o_col_sel    = r_v;
  assign o_x_sel      = r_i;
  assign o_beat_first = (r_i == 3'd0);
  assign o_beat_last  = (r_i == 3'd7);
  assign o_blk_last   = (r_u == 3'd7) && (r_v == 3'd7) && (r_i == 3'd7);

  // Level shift. The 9-bit difference always lies in [-128, 127], so its
  // low byte is the exact signed result.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      w_diff[j]  = {1'b0, r_mem[r_rd_bank][{r_i, 3'(j)}]} - 9'd128;
      o_x_row[j] = w_diff[j][7:0];
    end
  end

endmodule

// File: doc/dct_seq.md
# dct_seq

Block-buffer and sequencer directly upstream of the DCT coefficient ROM. Accepts 8-bit raster pixels of 8x8 blocks into a ping-pong buffer and level-shifts them by 128. For each output coefficient (u,v) it drives the ROM row/column selects and streams the eight level-shifted pixel rows X[i][0..7] to the downstream float MAC unit. That unit computes Y[u][v] = sum_i A[u][i]·(X[i]·A[v]).

## Interface
- No parameters. Pixel width is fixed at 8 and block size at 8x8.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel input valid
- pix_ready  out  1  pixel input ready
- pix_data  in  8  unsigned pixel, raster order within the block
- row_sel  out  3  to ROM row_sel, equal to u
- col_sel  out  3  to ROM col_sel, equal to v
- x_sel  out  3  index i; downstream picks row_vec[i] as A[u][i]
- x_row  out  8x8 signed  X[i][j] = pix(i,j) − 128, for j = 0..7
- beat_valid  out  1  beat valid
- beat_ready  in  1  beat accepted by downstream
- beat_first  out  1  beat has i = 0 (start of accumulation)
- beat_last  out  1  beat has i = 7 (coefficient complete)
- blk_last  out  1  beat has u = v = i = 7 (final beat of block)

## Operation
- Storage: two banks of 64 x 8-bit, addressed by (row, col). Bank contents are not reset.
- Write side:
  - Registers: wr_bank, 6-bit wr_cnt, full[1:0].
  - pix_ready = !full[wr_bank].
  - On each pix_valid & pix_ready, write pix_data to bank[wr_bank][wr_cnt] and increment wr_cnt.
  - On the write with wr_cnt = 63: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
- Read side FSM with states RD_IDLE and RD_RUN, plus registers rd_bank and counters u, v, i (3 bits each).
  - RD_IDLE → RD_RUN when full[rd_bank] = 1.
  - In RD_RUN, each beat_valid & beat_ready advances the counters: i fastest, then v, then u. That gives 512 beats per block.
  - On the accepted beat with blk_last = 1: clear full[rd_bank], toggle rd_bank, zero the counters, go to RD_IDLE.
- beat_valid = (state == RD_RUN).
  - All beat fields are combinational from the registered u, v, i, rd_bank and the bank contents (asynchronous read).
  - row_sel = u, col_sel = v, x_sel = i, x_row[j] = bank[rd_bank][i*8+j] − 128, computed as 9-bit then truncated. The result always fits in [−128, 127].
- Simultaneous events:
  - A full-set by the write side and a full-clear by the read side in the same cycle always target different banks, and both take effect.
  - A write into a bank is legal in the same cycle that the bank's full flag is cleared only if pix_ready was already high. Ready depends on registered full only, so a freed bank accepts pixels starting the next cycle.

## Timing
- Reset values (applied asynchronously):
  - wr_cnt = 0, wr_bank = 0, rd_bank = 0, u = v = i = 0, full = 00, state RD_IDLE.
  - Resulting outputs: pix_ready = 1, beat_valid = 0, row_sel = col_sel = x_sel = 0, beat_first = 1, beat_last = 0, blk_last = 0.
  - x_row is undefined (bank contents not reset).
- Latency: 64th pixel accepted at edge N → full set at N → RD_RUN entered at edge N+1. The first beat_valid is therefore the cycle after edge N+1.
- Throughput: one beat per cycle with beat_ready held high, so 512 cycles per block. Input accepts one pixel per cycle while a bank is free.
- Handshake:
  - While beat_valid & !beat_ready, every beat output holds stable.
  - beat_valid never drops without acceptance, except on reset.
- Back-pressure: when both banks are full, pix_ready = 0 until the cycle after the read side's final blk_last acceptance.
- Reset mid-block: all partial input and in-flight beats are discarded. After release, the first pixel accepted starts a new block at (0,0).

## Test plan
- Reset: hold rst_n low, then release → pix_ready = 1, beat_valid = 0, row_sel = col_sel = x_sel = 0, full = 00, with no beat until 64 pixels are written.
- Single block, pix_data = 0..63, beat_ready = 1:
  - Beat 0: u=v=i=0, beat_first = 1, x_row = −128..−121.
  - Beat 8: v = 1, i = 0.
  - Beat 511: u=v=i=7, beat_last = blk_last = 1, x_row = −72..−65.
  - Exactly 512 beats, then beat_valid = 0.
- Back-pressure: random 30% beat_ready on block pixels = 255 − k → all fields stable during stalls, beat order unchanged, every x_row[j] = 127 − (8i+j).
- Ping-pong: three back-to-back blocks with pix_valid = 1 and beat_ready = 1:
  - Block 2 loads in 64 cycles during block 1's compute.
  - pix_ready = 0 from block 2 full until the cycle after block 1's blk_last acceptance.
  - Block 2's beats follow block 1's with no gap cycle except the IDLE→RUN cycle.
- Input gaps: pix_valid 50% duty → block still fills after 64 accepted pixels, no duplicated or skipped addresses.
- Reset mid-operation: assert rst_n at beat 100 of block 1 while block 2 is half loaded → outputs return to reset values immediately. After release, a fresh block of 64 pixels yields beat 0 with u=v=i=0 and that block's data.
